// File: rtl/npu_wb_pkg.sv
// npu_wb_pkg: shared constants and state encoding for the NPU job sequencer.
//   W_BASE/S_BASE/R_BASE : adr[31:8] pages for weight writes, row writes, result reads
//   N_WEIGHTS, WEIGHT_STRIDE : weight count and byte stride inside the weight page
//   LAST_BIT : bit in a row write that flags the final input row
//   state_t  : sequencer FSM states
package npu_wb_pkg;

    localparam logic [23:0] W_BASE = 24'h3000_00;
    localparam logic [23:0] S_BASE = 24'h3000_01;
    localparam logic [23:0] R_BASE = 24'h3000_02;

    localparam int N_WEIGHTS     = 9;
    localparam int WEIGHT_STRIDE = 4;
    localparam int LAST_BIT      = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_SLOAD,
        ST_DRAIN,
        ST_RREAD,
        ST_RHOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/wbm_single.sv
// wbm_single: classic Wishbone single-transfer engine.
//   i_req/i_we/i_adr/i_dat : launch one transfer; only taken while o_busy is low
//   o_busy    : a bus cycle is open (cyc/stb high)
//   o_done    : ack sampled this cycle; cyc/stb drop on the coming edge
//   o_timeout : ack missing for TIMEOUT_CYC cycles; cyc/stb drop on the coming edge
//   o_rdata   : bus read data, valid together with o_done
//   o_cyc/o_stb/o_we/o_sel/o_adr/o_dat, i_wb_dat/i_wb_ack : Wishbone master side
// Macro NPU_WB_SEQ_TIMEOUT_EN adds the per-transfer watchdog; without it the
// engine waits for ack indefinitely and o_timeout is constant 0.
module wbm_single
`ifdef NPU_WB_SEQ_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 64
)
`endif
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout,
    output logic [31:0] o_rdata,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic [3:0]  o_sel,
    output logic [31:0] o_adr,
    output logic [31:0] o_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack
);

    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        w_ack;
    logic        w_to;

    // An ack outside an open cycle is ignored.
    assign w_ack = r_cyc & i_wb_ack;

`ifdef NPU_WB_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_tcnt;

    // Counts cycles of the open transfer; the 64th ack-less cycle closes it.
    assign w_to = r_cyc & ~i_wb_ack & (r_tcnt == T_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_tcnt <= '0;
        else if (!r_cyc)
            r_tcnt <= '0;
        else
            r_tcnt <= r_tcnt + 1'b1;
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (r_cyc) begin
            if (w_ack || w_to)
                r_cyc <= 1'b0;
        end else if (i_req) begin
            r_cyc <= 1'b1;
            r_we  <= i_we;
            r_adr <= i_adr;
            r_dat <= i_dat;
        end
    end

    assign o_busy    = r_cyc;
    assign o_done    = w_ack;
    assign o_timeout = w_to;
    assign o_rdata   = i_wb_dat;
    assign o_cyc     = r_cyc;
    assign o_stb     = r_cyc;
    assign o_we      = r_cyc & r_we;
    assign o_sel     = r_cyc ? 4'hF : 4'h0;
    assign o_adr     = r_adr;
    assign o_dat     = r_dat;

endmodule

// File: rtl/npu_wb_seq.sv
// npu_wb_seq: Wishbone initiator that runs one full NPU job: 9 weight writes,
// N_IN input-row writes (last row flagged), a DRAIN_CYC idle gap, then N_OUT
// result reads handed out on a valid/ready stream.
//   wb_clk_i, wb_rst_i (async, active-high)
//   start_i, busy_o, done_o, err_o           : job control / status
//   w_valid_i/w_ready_o/w_data_i             : weight stream in
//   s_valid_i/s_ready_o/s_data_i             : input-row stream in
//   r_valid_o/r_ready_i/r_data_o             : result stream out
//   wbm_*                                    : Wishbone master to the NPU slave
// Macro NPU_WB_SEQ_TIMEOUT_EN: a transfer without ack for TIMEOUT_CYC cycles
// aborts the job through DONE and sets sticky err_o. Undefined: err_o stays 0.
module npu_wb_seq
    import npu_wb_pkg::*;
#(
    parameter int N_IN      = 6,
    parameter int N_OUT     = 9,
    parameter int DRAIN_CYC = 16
`ifdef NPU_WB_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
)(
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic        w_valid_i,
    output logic        w_ready_o,
    input  logic [23:0] w_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [23:0] s_data_i,
    output logic        r_valid_o,
    input  logic        r_ready_i,
    output logic [31:0] r_data_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_we;
    logic [31:0] w_adr;
    logic [31:0] w_dat;
    logic        w_busy;
    logic        w_done;
    logic        w_to;
    logic [31:0] w_rdata;
    logic        w_last;

    assign w_last = (r_cnt == 8'(N_IN - 1));

    wbm_single
`ifdef NPU_WB_SEQ_TIMEOUT_EN
    #(.TIMEOUT_CYC(TIMEOUT_CYC))
`endif
    u_wbm (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_req     (w_req),
        .i_we      (w_we),
        .i_adr     (w_adr),
        .i_dat     (w_dat),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_timeout (w_to),
        .o_rdata   (w_rdata),
        .o_cyc     (wbm_cyc_o),
        .o_stb     (wbm_stb_o),
        .o_we      (wbm_we_o),
        .o_sel     (wbm_sel_o),
        .o_adr     (wbm_adr_o),
        .o_dat     (wbm_dat_o),
        .i_wb_dat  (wbm_dat_i),
        .i_wb_ack  (wbm_ack_i)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Streams are only ready while the engine is idle, so an accepted word is
    // registered into the engine and appears on the bus the following cycle.
    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_we      = 1'b0;
        w_adr     = '0;
        w_dat     = '0;
        w_ready_o = 1'b0;
        s_ready_o = 1'b0;
        r_valid_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i)
                    w_next = ST_WLOAD;
            end
            ST_WLOAD: begin
                w_ready_o = !w_busy;
                w_req     = w_valid_i && !w_busy;
                w_we      = 1'b1;
                w_adr     = {W_BASE, 8'(r_cnt * WEIGHT_STRIDE)};
                w_dat     = {8'h00, w_data_i};
                if (w_to)
                    w_next = ST_DONE;
                else if (w_done && r_cnt == 8'(N_WEIGHTS - 1))
                    w_next = ST_SLOAD;
            end
            ST_SLOAD: begin
                s_ready_o       = !w_busy;
                w_req           = s_valid_i && !w_busy;
                w_we            = 1'b1;
                w_adr           = {S_BASE, 8'h00};
                w_dat           = {8'h00, s_data_i};
                w_dat[LAST_BIT] = w_last;
                if (w_to)
                    w_next = ST_DONE;
                else if (w_done && w_last)
                    w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_cnt == 8'(DRAIN_CYC - 1))
                    w_next = ST_RREAD;
            end
            ST_RREAD: begin
                w_req = !w_busy;
                w_adr = {R_BASE, r_cnt};
                if (w_to)
                    w_next = ST_DONE;
                else if (w_done)
                    w_next = ST_RHOLD;
            end
            ST_RHOLD: begin
                r_valid_o = 1'b1;
                if (r_ready_i)
                    w_next = (r_cnt == 8'(N_OUT - 1)) ? ST_DONE : ST_RREAD;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // One counter serves each phase in turn: weight k, row j, drain cycles,
    // result i. Each phase hands over with it back at zero.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_to)
                r_err <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (start_i)
                        r_err <= 1'b0;
                end
                ST_WLOAD: begin
                    if (w_done)
                        r_cnt <= (r_cnt == 8'(N_WEIGHTS - 1)) ? 8'd0 : r_cnt + 8'd1;
                end
                ST_SLOAD: begin
                    if (w_done)
                        r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
                end
                ST_DRAIN: begin
                    r_cnt <= (r_cnt == 8'(DRAIN_CYC - 1)) ? 8'd0 : r_cnt + 8'd1;
                end
                ST_RREAD: begin
                    if (w_done)
                        r_rdata <= w_rdata;
                end
                ST_RHOLD: begin
                    if (r_ready_i)
                        r_cnt <= r_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (r_state != ST_IDLE);
    assign done_o   = (r_state == ST_DONE);
    assign err_o    = r_err;
    assign r_data_o = r_rdata;

endmodule

// File: tb/tb_npu_wb_seq.sv
module tb_npu_wb_seq;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start_i;
    logic        busy_o, done_o, err_o;
    logic        w_valid_i, w_ready_o;
    logic [23:0] w_data_i;
    logic        s_valid_i, s_ready_o;
    logic [23:0] s_data_i;
    logic        r_valid_o, r_ready_i;
    logic [31:0] r_data_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;

    npu_wb_seq dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int errors = 0;
    int checks = 0;

    // NPU slave model: ack one cycle after stb, result word = index + 1.
    logic no_ack = 1'b0;
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) wbm_ack_i <= 1'b0;
        else          wbm_ack_i <= !no_ack && wbm_cyc_o && wbm_stb_o && !wbm_ack_i;
    end
    assign wbm_dat_i = {24'h0, wbm_adr_o[7:0]} + 32'd1;

    logic [23:0] wv [9] = '{24'hABCDEF, 24'h123456, 24'h000001, 24'h7FFFFF, 24'h800000,
                            24'hFFFFFF, 24'h00FF00, 24'h0A0B0C, 24'h5A5A5A};
    logic [23:0] sv [6] = '{24'h030201, 24'h060504, 24'h090807, 24'hFFFFFF, 24'h000000, 24'h112233};

    logic [31:0] t_adr[$], t_dat[$], res[$];
    logic        t_we[$];
    int done_cyc, done_cnt, gap_bad, stall_bad, sel_bad;

    // Drives one job cycle by cycle on the falling edge and logs what the bus
    // and result stream do. done_cyc counts cycles from the start_i cycle (0).
    task automatic run_job(input bit hold_start, input int gap_at, input int gap_len,
                           input int stall_at, input int stall_len, input int abort_at);
        int wi, si, ri, gap_rem, stall_rem;
        logic [31:0] held;
        t_adr.delete(); t_dat.delete(); t_we.delete(); res.delete();
        done_cyc = -1; done_cnt = 0; gap_bad = 0; stall_bad = 0; sel_bad = 0;
        wi = 0; si = 0; ri = 0; gap_rem = gap_len; stall_rem = stall_len; held = '0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge wb_clk_i);
            start_i   = (k == 0) || hold_start;
            w_valid_i = (wi < 9);
            w_data_i  = (wi < 9) ? wv[wi] : 24'h0;
            if (si == gap_at && gap_rem > 0) begin
                s_valid_i = 1'b0;
                if (gap_rem <= gap_len - 2 && wbm_cyc_o) gap_bad++;
                gap_rem--;
            end else begin
                s_valid_i = (si < 6);
            end
            s_data_i  = (si < 6) ? sv[si] : 24'h0;
            r_ready_i = 1'b1;
            if (ri == stall_at && r_valid_o && stall_rem > 0) begin
                r_ready_i = 1'b0;
                if (stall_rem == stall_len) held = r_data_o;
                else if (r_data_o !== held || wbm_cyc_o) stall_bad++;
                stall_rem--;
            end
            if ((wbm_cyc_o && wbm_sel_o !== 4'hF) || (!wbm_cyc_o && wbm_sel_o !== 4'h0) ||
                wbm_stb_o !== wbm_cyc_o) sel_bad++;
            if (wbm_cyc_o && wbm_ack_i) begin
                t_adr.push_back(wbm_adr_o); t_dat.push_back(wbm_dat_o); t_we.push_back(wbm_we_o);
            end
            if (r_valid_o && r_ready_i) begin res.push_back(r_data_o); ri++; end
            if (w_valid_i && w_ready_o) wi++;
            if (s_valid_i && s_ready_o) si++;
            if (done_o) begin done_cnt++; done_cyc = k; break; end
            if (abort_at >= 0 && si == abort_at) break;
        end
        start_i = 1'b0; w_valid_i = 1'b0; s_valid_i = 1'b0; r_ready_i = 1'b1;
    endtask

    task automatic test_reset;
        wb_rst_i = 1'b1; start_i = 0; w_valid_i = 0; s_valid_i = 0; r_ready_i = 1;
        w_data_i = '0; s_data_i = '0;
        repeat (3) @(negedge wb_clk_i);
        checks++;
        if ({busy_o, done_o, err_o, w_ready_o, s_ready_o, r_valid_o} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000",
                               {busy_o, done_o, err_o, w_ready_o, s_ready_o, r_valid_o});
        end
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== '0) begin
            errors++; $display("FAIL reset_bus cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h exp all 0",
                               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
        end
        checks++;
        if (r_data_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got=%h exp=0", r_data_o);
        end
        wb_rst_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL idle_no_start busy got=%b exp=0", busy_o);
        end
    endtask

    task automatic test_full_job;
        run_job(0, -1, 0, -1, 0, -1);
        checks++;
        if (done_cyc !== 98) begin errors++; $display("FAIL full_latency got=%0d exp=98", done_cyc); end
        checks++;
        if (t_adr.size() !== 24) begin errors++; $display("FAIL full_xfers got=%0d exp=24", t_adr.size()); end
        checks++;
        if (res.size() !== 9) begin errors++; $display("FAIL full_results got=%0d exp=9", res.size()); end
        checks++;
        if (sel_bad !== 0) begin errors++; $display("FAIL full_sel_stb got=%0d bad cycles exp=0", sel_bad); end
        if (t_adr.size() == 24) begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (t_adr[k] !== 32'h3000_0000 + 32'(k * 4) || t_dat[k] !== {8'h00, wv[k]} || t_we[k] !== 1'b1) begin
                    errors++; $display("FAIL weight%0d adr=%h dat=%h we=%b exp adr=%h dat=%h we=1",
                                       k, t_adr[k], t_dat[k], t_we[k], 32'h3000_0000 + 32'(k * 4), {8'h00, wv[k]});
                end
            end
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (t_adr[9+j] !== 32'h3000_0100 || t_we[9+j] !== 1'b1 ||
                    t_dat[9+j] !== ({8'h00, sv[j]} | ((j == 5) ? 32'h0100_0000 : 32'h0))) begin
                    errors++; $display("FAIL row%0d adr=%h dat=%h we=%b exp adr=30000100 dat=%h",
                                       j, t_adr[9+j], t_dat[9+j], t_we[9+j],
                                       {8'h00, sv[j]} | ((j == 5) ? 32'h0100_0000 : 32'h0));
                end
            end
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (t_adr[15+i] !== 32'h3000_0200 + 32'(i) || t_we[15+i] !== 1'b0) begin
                    errors++; $display("FAIL read%0d adr=%h we=%b exp adr=%h we=0",
                                       i, t_adr[15+i], t_we[15+i], 32'h3000_0200 + 32'(i));
                end
            end
        end
        if (res.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (res[i] !== 32'(i + 1)) begin
                    errors++; $display("FAIL result%0d got=%h exp=%h", i, res[i], 32'(i + 1));
                end
            end
        end
        @(negedge wb_clk_i);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL full_after done=%b busy=%b exp 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_stalls;
        // Row 3 withheld 20 cycles (+18), result 3 refused 10 cycles (+10).
        run_job(0, 3, 20, 2, 10, -1);
        checks++;
        if (done_cyc !== 126) begin errors++; $display("FAIL stall_latency got=%0d exp=126", done_cyc); end
        checks++;
        if (gap_bad !== 0) begin errors++; $display("FAIL gap_bus_idle got=%0d busy cycles exp=0", gap_bad); end
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL rhold_stable got=%0d bad cycles exp=0", stall_bad); end
        checks++;
        if (t_adr.size() !== 24) begin errors++; $display("FAIL stall_xfers got=%0d exp=24", t_adr.size()); end
        if (t_adr.size() == 24) begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (t_dat[9+j] !== ({8'h00, sv[j]} | ((j == 5) ? 32'h0100_0000 : 32'h0))) begin
                    errors++; $display("FAIL stall_row%0d got=%h exp=%h", j, t_dat[9+j],
                                       {8'h00, sv[j]} | ((j == 5) ? 32'h0100_0000 : 32'h0));
                end
            end
        end
        if (res.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (res[i] !== 32'(i + 1)) begin
                    errors++; $display("FAIL stall_result%0d got=%h exp=%h", i, res[i], 32'(i + 1));
                end
            end
        end else begin
            checks++; errors++; $display("FAIL stall_results got=%0d exp=9", res.size());
        end
    endtask

    task automatic test_start_busy;
        run_job(1, -1, 0, -1, 0, -1);
        checks++;
        if (done_cyc !== 98 || done_cnt !== 1) begin
            errors++; $display("FAIL start_busy latency=%0d dones=%0d exp 98 1", done_cyc, done_cnt);
        end
        repeat (3) @(negedge wb_clk_i);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL start_busy_after busy=%b done=%b exp 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_reset_mid;
        run_job(0, -1, 0, -1, 0, 2);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy_o); end
        #2 wb_rst_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o, s_ready_o, w_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 7'b0 ||
            wbm_sel_o !== 4'h0 || wbm_adr_o !== 32'h0 || r_data_o !== 32'h0) begin
            errors++; $display("FAIL mid_reset busy=%b cyc=%b sel=%h adr=%h rdata=%h exp all 0",
                               busy_o, wbm_cyc_o, wbm_sel_o, wbm_adr_o, r_data_o);
        end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        run_job(0, -1, 0, -1, 0, -1);
        checks++;
        if (t_adr.size() == 0 || t_adr[0] !== 32'h3000_0000 || t_dat[0] !== 32'h00AB_CDEF) begin
            errors++; $display("FAIL restart_first n=%0d adr=%h dat=%h exp adr=30000000 dat=00abcdef",
                               t_adr.size(), (t_adr.size() > 0) ? t_adr[0] : 32'h0,
                               (t_dat.size() > 0) ? t_dat[0] : 32'h0);
        end
        checks++;
        if (done_cyc !== 98 || t_adr.size() !== 24) begin
            errors++; $display("FAIL restart_job latency=%0d xfers=%0d exp 98 24", done_cyc, t_adr.size());
        end
    endtask

`ifdef NPU_WB_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int hi, k;
        hi = 0;
        no_ack = 1'b1;
        @(negedge wb_clk_i); start_i = 1; w_valid_i = 1; w_data_i = wv[0];
        @(negedge wb_clk_i); start_i = 0;
        @(negedge wb_clk_i); w_valid_i = 0;
        for (k = 0; k < 200 && !done_o; k++) begin
            if (wbm_cyc_o) hi++;
            @(negedge wb_clk_i);
        end
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL to_done got=%b exp=1", done_o); end
        checks++;
        if (hi !== 64) begin errors++; $display("FAIL to_cyc_len got=%0d exp=64", hi); end
        checks++;
        if (err_o !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            errors++; $display("FAIL to_err err=%b cyc=%b exp 1 0", err_o, wbm_cyc_o);
        end
        no_ack = 1'b0;
        @(negedge wb_clk_i); start_i = 1;
        @(negedge wb_clk_i); start_i = 0;
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL to_err_clear got=%b exp=0", err_o); end
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i); wb_rst_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_full_job;
        test_stalls;
        test_start_busy;
        test_reset_mid;
`ifdef NPU_WB_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/npu_wb_seq.md
# npu_wb_seq

Wishbone initiator that drives the systolic-array NPU slave on the Caravel bus through one complete job: load the nine weights, stream the input rows (final row flagged), wait a fixed drain interval, then read back the results. It sits between a local controller (streaming valid/ready ports) and the NPU's Wishbone responder, and replaces firmware-driven register pokes with a deterministic hardware sequence.

## Interface
- W_BASE, 24'h3000_00, adr[31:8] page for weight writes
- S_BASE, 24'h3000_01, adr[31:8] page for input-row writes
- R_BASE, 24'h3000_02, adr[31:8] page for result reads
- N_IN, 6, input rows per job (1..255)
- N_OUT, 9, result words per job (1..255)
- DRAIN_CYC, 16, idle cycles between last input write and first read (1..255)
- TIMEOUT_CYC, 64, cycles without ack before abort (with timeout feature)

- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  begin job; sampled in IDLE only
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse on job completion
- err_o  out  1  sticky timeout flag; cleared by next accepted start_i
- w_valid_i / w_ready_o  in/out  1/1  weight stream handshake
- w_data_i  in  24  weight word
- s_valid_i / s_ready_o  in/out  1/1  input-row stream handshake
- s_data_i  in  24  row {in3,in2,in1} bytes
- r_valid_o / r_ready_i  out/in  1/1  result stream handshake
- r_data_o  out  32  result word
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master strobes
- wbm_sel_o  out  4  always 4'hF during a cycle, else 0
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  ack

## Operation
- States: IDLE, WLOAD, SLOAD, DRAIN, RREAD, RHOLD, DONE.
- IDLE: start_i -> WLOAD; counters zeroed; err_o cleared.
- WLOAD: for k=0..8: accept one weight (w_ready_o high only while no bus cycle is pending), then write adr={W_BASE,8'(k*4)}, dat={8'h00,w_data_i}. After 9th ack -> SLOAD.
- SLOAD: for j=0..N_IN-1: accept row, write adr={S_BASE,8'h00}, dat={7'h0, last, s_data_i}, last = (j==N_IN-1). After last ack -> DRAIN.
- DRAIN: count DRAIN_CYC cycles, no bus activity -> RREAD.
- RREAD: read adr={R_BASE,8'(i)}, i=0..N_OUT-1; on ack capture wbm_dat_i into r_data_o, -> RHOLD.
- RHOLD: r_valid_o high until r_ready_i; on handshake i++; more -> RREAD, else -> DONE.
- DONE: done_o=1 for one cycle -> IDLE.
- Bus cycle: classic single transfer; cyc=stb=1 with stable adr/dat/we until the cycle wbm_ack_i is sampled high; cyc/stb drop on that edge; minimum one idle cycle between transfers. wbm_ack_i outside a cycle ignored.
- Reset mid-job: immediate return to IDLE, bus released, captured data discarded; no done_o.

## Timing
- Reset values: busy_o, done_o, err_o, w_ready_o, s_ready_o, r_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; wbm_sel_o, wbm_adr_o, wbm_dat_o, r_data_o = 0.
- Stream accept to cyc/stb assertion: 1 cycle (data registered).
- NPU slave acks one cycle after stb: write transfer = 2 cycles + 1 idle = 3 cycles per word.
- Read: ack edge -> r_valid_o next cycle; same-cycle r_ready_i completes the beat; next read issues the cycle after.
- start_i while busy_o ignored. Streams stalled (valid low) hold the FSM indefinitely with bus idle.
- Job with zero stall, r_ready_i tied high: 1 + 27 + 3*N_IN + DRAIN_CYC + 4*N_OUT + 1 cycles, start to done_o.

## Configuration
- NPU_WB_SEQ_TIMEOUT_EN defined: per-transfer counter; ack absent for TIMEOUT_CYC cycles -> drop cyc/stb, set err_o, -> DONE (done_o still pulses).
- Undefined: no counter, waits for ack forever; err_o tied 0.

## Structure
- Package npu_wb_pkg: page constants W_BASE/S_BASE/R_BASE, weight count 9, weight stride 4, last-flag bit position 24, state enum.
- Sub-module wbm_single: one-transfer engine (req/we/adr/dat in, done/rdata out, timeout optional); sequencer FSM in npu_wb_seq instantiates it.

## Test plan
- Full job, N_IN=6, N_OUT=9, slave model acking after 1 cycle -> writes at 0x3000_0000..0x3000_0020 step 4, 6 writes to 0x3000_0100 with bit24 set only on 6th, reads 0x3000_0200..0x3000_0208, done_o once.
- Weight 24'hABCDEF -> wbm_dat_o=32'h00ABCDEF on first write; results 1..9 from slave -> r_data_o 1..9 in order.
- s_valid_i dropped 20 cycles mid-SLOAD -> cyc low throughout gap, sequence resumes unchanged.
- r_ready_i low 10 cycles on result 3 -> r_data_o held stable, no new read issued.
- Slave never acks with NPU_WB_SEQ_TIMEOUT_EN, TIMEOUT_CYC=64 -> cyc drops 64 cycles after stb, err_o=1, done_o pulse; next start_i clears err_o.
- wb_rst_i asserted mid-SLOAD -> outputs to reset values asynchronously; new start_i restarts at weight 0.
